// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall control for the 5-stage pipeline.
// Operand hazards, branch flush and data-memory handshake FSM with timeout.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             id_is_branch,
  input  logic             id_branch_taken,
  input  logic [4:0]       ex_reg_addr,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_reg_addr,
  input  logic             mem_mem_read,
  input  logic             mem_mem_write,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             mem_stall,
  output logic             stall,
  output logic             if_id_nop,
  output logic             id_ex_nop,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mstall_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  logic ex_nz, mem_nz;
  logic rs1_ex, rs2_ex, rs1_mm, rs2_mm;
  logic lu, bex, bmm, haz;
  logic acc, req, ms;

  assign ex_nz  = ex_reg_addr != 5'd0;
  assign mem_nz = mem_reg_addr != 5'd0;

  assign rs1_ex = id_rs1_used && (id_rs1_addr == ex_reg_addr);
  assign rs2_ex = id_rs2_used && (id_rs2_addr == ex_reg_addr);
  assign rs1_mm = id_rs1_used && (id_rs1_addr == mem_reg_addr);
  assign rs2_mm = id_rs2_used && (id_rs2_addr == mem_reg_addr);

  assign lu  = ex_mem_read && ex_nz && (rs1_ex || rs2_ex);
  assign bex = id_is_branch && ex_nz && (rs1_ex || rs2_ex);
  assign bmm = id_is_branch && mem_mem_read && mem_nz
            && (rs1_mm || rs2_mm);
  assign haz = lu || bex || bmm;

  // A pending stall defers the flush until operands are ready
  assign stall     = rst_n && haz;
  assign id_ex_nop = rst_n && haz;
  assign if_id_nop = rst_n && id_branch_taken && !haz;

  assign acc = mem_mem_read || mem_mem_write;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    req     = 1'b0;
    ms      = 1'b0;
    unique case (state_q)
      IDLE: begin
        req = acc;
        ms  = acc && !dmem_ready;
        if (acc && !dmem_ready) begin
          state_d = BUSY;
          timer_d = TW'(1);
        end
      end
      BUSY: begin
        req = 1'b1;
        ms  = !dmem_ready;
        if (dmem_ready) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == TW'(TIMEOUT)) begin
          state_d = ERROR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ERROR: begin
        ms = 1'b1;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign dmem_req  = rst_n && req;
  assign mem_stall = rst_n && ms;
  assign mem_err   = rst_n && (state_q == ERROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      mstall_cnt <= '0;
    end else begin
      if (haz && !ms)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (id_branch_taken && !haz && !ms)
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (ms)
        mstall_cnt <= mstall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed cases plus random
// traffic against a behavioural model (TIMEOUT=4, CNT_W=4).
module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1_addr, id_rs2_addr;
  logic id_rs1_used, id_rs2_used;
  logic id_is_branch, id_branch_taken;
  logic [4:0] ex_reg_addr, mem_reg_addr;
  logic ex_mem_read, mem_mem_read, mem_mem_write;
  logic dmem_ready;
  logic dmem_req, mem_stall, stall, if_id_nop;
  logic id_ex_nop, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt, mstall_cnt;

  pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .id_is_branch(id_is_branch),
    .id_branch_taken(id_branch_taken),
    .ex_reg_addr(ex_reg_addr),
    .ex_mem_read(ex_mem_read),
    .mem_reg_addr(mem_reg_addr),
    .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write),
    .dmem_ready(dmem_ready),
    .dmem_req(dmem_req),
    .mem_stall(mem_stall),
    .stall(stall),
    .if_id_nop(if_id_nop),
    .id_ex_nop(id_ex_nop),
    .mem_err(mem_err),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
    .mstall_cnt(mstall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit m_busy, m_err;
  int m_wait;
  int m_sc, m_fc, m_mc;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    id_rs1_addr = '0; id_rs2_addr = '0;
    id_rs1_used = 0; id_rs2_used = 0;
    id_is_branch = 0; id_branch_taken = 0;
    ex_reg_addr = '0; ex_mem_read = 0;
    mem_reg_addr = '0; mem_mem_read = 0;
    mem_mem_write = 0; dmem_ready = 0;
  endtask

  task automatic rand_in();
    id_rs1_addr = 5'($urandom_range(0, 3));
    id_rs2_addr = 5'($urandom_range(0, 3));
    id_rs1_used = 1'($urandom_range(0, 1));
    id_rs2_used = 1'($urandom_range(0, 1));
    id_is_branch = 1'($urandom_range(0, 1));
    id_branch_taken = 1'($urandom_range(0, 1));
    ex_reg_addr = 5'($urandom_range(0, 3));
    ex_mem_read = 1'($urandom_range(0, 1));
    mem_reg_addr = 5'($urandom_range(0, 3));
    mem_mem_read = ($urandom_range(0, 2) == 0);
    mem_mem_write = ($urandom_range(0, 2) == 0);
    dmem_ready = ($urandom_range(0, 9) < 6);
  endtask

  function automatic bit ref_hazard();
    logic [4:0] rs [2];
    bit used [2];
    bit h = 0;
    rs[0] = id_rs1_addr; rs[1] = id_rs2_addr;
    used[0] = id_rs1_used; used[1] = id_rs2_used;
    for (int i = 0; i < 2; i++) begin
      if (used[i] && rs[i] != 0) begin
        if (rs[i] == ex_reg_addr && (ex_mem_read || id_is_branch))
          h = 1;
        if (rs[i] == mem_reg_addr && id_is_branch && mem_mem_read)
          h = 1;
      end
    end
    return h;
  endfunction

  // one clock: check combinational outputs mid-cycle, then advance model
  task automatic step();
    bit h, f, req, ms, acc, rdy;
    @(negedge clk);
    h   = ref_hazard();
    f   = id_branch_taken && !h;
    acc = mem_mem_read || mem_mem_write;
    rdy = dmem_ready;
    if (m_err) begin
      req = 0; ms = 1;
    end else if (m_busy) begin
      req = 1; ms = !rdy;
    end else begin
      req = acc; ms = acc && !rdy;
    end
    check("stall", 32'(stall), 32'(h));
    check("id_ex_nop", 32'(id_ex_nop), 32'(h));
    check("if_id_nop", 32'(if_id_nop), 32'(f));
    check("dmem_req", 32'(dmem_req), 32'(req));
    check("mem_stall", 32'(mem_stall), 32'(ms));
    check("mem_err", 32'(mem_err), 32'(m_err));
    check("stall_cnt", 32'(stall_cnt), 32'(m_sc % 16));
    check("flush_cnt", 32'(flush_cnt), 32'(m_fc % 16));
    check("mstall_cnt", 32'(mstall_cnt), 32'(m_mc % 16));
    @(posedge clk);
    if (h && !ms) m_sc++;
    if (f && !ms) m_fc++;
    if (ms) m_mc++;
    if (!m_err) begin
      if (m_busy) begin
        if (rdy) m_busy = 0;
        else if (m_wait == TO) begin
          m_busy = 0; m_err = 1;
        end else m_wait++;
      end else if (acc && !rdy) begin
        m_busy = 1; m_wait = 1;
      end
    end
    #1;
  endtask

  // asynchronous reset asserted away from any clock edge
  task automatic do_reset();
    rst_n = 0;
    #1;
    check("rst_req", 32'(dmem_req), 0);
    check("rst_mstall", 32'(mem_stall), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_ifnop", 32'(if_id_nop), 0);
    check("rst_idnop", 32'(id_ex_nop), 0);
    check("rst_err", 32'(mem_err), 0);
    check("rst_cnts", 32'({stall_cnt, flush_cnt, mstall_cnt}), 0);
    m_busy = 0; m_err = 0; m_wait = 0;
    m_sc = 0; m_fc = 0; m_mc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    clr_in();
    #2;
    do_reset();

    // load-use, then x0 never hazards
    ex_mem_read = 1; ex_reg_addr = 5; id_rs1_addr = 5; id_rs1_used = 1;
    step();
    clr_in();
    step();
    ex_mem_read = 1; id_rs1_used = 1;
    step();
    check("t1_stall_cnt", 32'(stall_cnt), 1);

    // branch: ALU in EX then load in EX/MEM
    do_reset();
    clr_in();
    id_is_branch = 1; id_rs1_addr = 6; id_rs1_used = 1; ex_reg_addr = 6;
    step();
    ex_mem_read = 1;
    step();
    ex_mem_read = 0; ex_reg_addr = 0; mem_reg_addr = 6; mem_mem_read = 1;
    dmem_ready = 1;
    step();
    check("t2_stall_cnt", 32'(stall_cnt), 3);

    // taken branch flush, suppressed by load-use
    do_reset();
    clr_in();
    id_branch_taken = 1;
    step();
    ex_mem_read = 1; ex_reg_addr = 7; id_rs2_addr = 7; id_rs2_used = 1;
    step();
    check("t3_flush_cnt", 32'(flush_cnt), 1);
    check("t3_stall_cnt", 32'(stall_cnt), 1);

    // store with three wait cycles
    do_reset();
    clr_in();
    mem_mem_write = 1;
    repeat (3) step();
    dmem_ready = 1;
    step();
    clr_in();
    step();
    check("t4_mstall_cnt", 32'(mstall_cnt), 3);

    // timeout into sticky error
    do_reset();
    clr_in();
    mem_mem_read = 1;
    repeat (8) step();
    check("t5_err", 32'(mem_err), 1);
    check("t5_mstall", 32'(mem_stall), 1);

    // reset while busy
    do_reset();
    clr_in();
    mem_mem_write = 1;
    repeat (2) step();
    do_reset();
    clr_in();
    step();
    check("t6_err", 32'(mem_err), 0);

    // 17 stall cycles on a 4-bit counter wrap to 1
    do_reset();
    clr_in();
    ex_mem_read = 1; ex_reg_addr = 3; id_rs1_addr = 3; id_rs1_used = 1;
    repeat (17) step();
    check("wrap_stall_cnt", 32'(stall_cnt), 1);

    // random traffic with periodic reset
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) do_reset();
      rand_in();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
